led_bank_arbiter: RTL and testbench
===================================

// Module: led_bank_arbiter
// PURPOSE
//  Shares the 8-bit front-panel LED bank between the idle display (cylon eye) and 3 alert requesters.
//  Fixed priority: highest index wins. Each alert is held for a minimum visible time in prescaled ticks,
//  with optional blink. Sits between the cylon generator and the LED output pins.
// PARAMETERS
//  MXPRE       21  prescaler width; tick = one clock every 2**MXPRE clocks (bench uses 3)
//  HOLD_TICKS  4   minimum alert display time in ticks; legal range >=1
// PORTS
//  clock     in   1   system clock
//  reset_n   in   1   asynchronous, active-low reset
//  idle_pat  in   8   idle pattern, from cylon generator
//  req       in   3   alert requests, level; req[i] keeps alert i displayed while high
//  pat       in   24  alert patterns, pat[8i+7:8i] for requester i; sampled at grant
//  blink     in   3   per-requester blink enable; sampled at grant
//  ack       out  3   one-clock pulse when alert i leaves the display
//  busy      out  1   1 while an alert owns the bank (SHOW state)
//  owner     out  2   0 = idle pattern; i+1 = alert i
//  q         out  8   registered LED drive
// BEHAVIOUR
//  Reset (async on reset_n low):
//   - q=0, ack=0, busy=0, owner=0, state=IDLE.
//   - prescaler=0, hold_cnt=0, phase=1. No ack is generated for an alert cut off by reset.
//  Prescaler: free-running MXPRE-bit up-counter; tick=1 for one clock when it is all ones.
//  States IDLE, SHOW, DONE. hold_cnt is $clog2(HOLD_TICKS+1) bits wide and saturates at HOLD_TICKS.
//  IDLE, no req: q <= idle_pat every clock (1-clock latency), owner=0, busy=0.
//  IDLE, any req: grant k = highest set index.
//   - Latch pat_r <= pat[k], blink_r <= blink[k].
//   - hold_cnt <= 0, phase <= 1, owner <= k+1, busy <= 1.
//   - q <= pat[k] on the same edge. Next state SHOW.
//  SHOW:
//   - q <= (blink_r & ~phase) ? 8'h00 : pat_r.
//   - On each tick: hold_cnt++ (saturating); phase toggles.
//   - A tick on the grant edge is not counted.
//   - Leave to DONE when hold_cnt==HOLD_TICKS AND (req[k]==0 OR any req[j], j>k).
//   - req[k] dropping before the minimum hold is ignored.
//   - Lower-priority requests never preempt.
//   - Changes to pat/blink during SHOW are ignored.
//  DONE (exactly 1 clock):
//   - ack[k]=1 for this clock only; q <= idle_pat; owner <= 0; busy <= 0. Next state IDLE.
//   - A pending request is granted on the following IDLE clock.
//  Preempted requester whose req is still high is re-granted later as a new display:
//   - Pattern is re-sampled; hold restarts; it gets a second ack.
//  Simultaneous requests in IDLE: highest index wins; the others stay pending (req is level).
//  ack is one-hot or zero; busy==(owner!=0) at all times.
// TESTING (bench: MXPRE=3 -> tick every 8 clocks, HOLD_TICKS=2)
//  1 Reset asserted, then released with idle_pat=8'h01, req=0
//    -> q=00 during reset; q=01 one clock after release; owner=0, ack=0.
//  2 req[0] pulsed 1 clock, pat[7:0]=A5, blink=0
//    -> q=A5 from next edge; 2 ticks later DONE: ack[0] 1 clock; q=01 thereafter.
//  3 req[2] held 10 ticks, pat[23:16]=3C
//    -> q=3C for all 10 ticks; DONE the clock after req[2] drops; ack[2] only.
//  4 req[0] held, req[2] raised after 1 tick
//    -> no switch until hold_cnt=2; then ack[0]; grant 2 (owner=3);
//       after req[2] drops, ack[2]; alert 0 re-granted (owner=1).
//  5 req[1] with blink[1]=1, pat[15:8]=FF
//    -> q alternates FF/00 on each tick, starting FF at grant; ack[1] after release.
//  6 reset_n pulled low mid-SHOW
//    -> q=00, busy=0, owner=0 immediately (asynchronous); no ack pulse.
//       After release, the bank returns to the idle pattern.

Source files
------------

// File: rtl/led_bank_arbiter.sv
// Shares the 8-bit LED bank between the idle (cylon) pattern and three alert
// requesters; highest index wins, and each alert is held a minimum number of ticks.
module led_bank_arbiter #(
  parameter int MXPRE      = 21,
  parameter int HOLD_TICKS = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  idle_pat,
  input  logic [2:0]  req,
  input  logic [23:0] pat,
  input  logic [2:0]  blink,
  output logic [2:0]  ack,
  output logic        busy,
  output logic [1:0]  owner,
  output logic [7:0]  q
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHOW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [MXPRE-1:0] prescaler;
  logic             tick;
  logic [HW-1:0]    hold_cnt;
  logic             phase;
  logic [7:0]       pat_r;
  logic             blink_r;
  logic [1:0]       grant_idx;
  logic [1:0]       cur_idx;
  logic [7:0]       pat_sel;
  logic             blink_sel;
  logic             cur_req;
  logic             higher_req;

  assign tick    = &prescaler;
  // owner holds the granted index plus one, so the current alert needs no extra register
  assign cur_idx = owner - 2'd1;

  always_comb begin
    grant_idx  = 2'd0;
    pat_sel    = 8'h00;
    blink_sel  = 1'b0;
    cur_req    = 1'b0;
    higher_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (req[i]) grant_idx = 2'(i);
      if (req[i] && (2'(i) > cur_idx)) higher_req = 1'b1;
      if (2'(i) == cur_idx) cur_req = req[i];
    end
    for (int i = 0; i < 3; i++) begin
      if (2'(i) == grant_idx) begin
        pat_sel   = pat[8*i +: 8];
        blink_sel = blink[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) prescaler <= '0;
    else          prescaler <= prescaler + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      q        <= 8'h00;
      ack      <= 3'b000;
      busy     <= 1'b0;
      owner    <= 2'd0;
      hold_cnt <= '0;
      phase    <= 1'b1;
      pat_r    <= 8'h00;
      blink_r  <= 1'b0;
    end else begin
      ack <= 3'b000;
      case (state)
        IDLE: begin
          if (|req) begin
            pat_r    <= pat_sel;
            blink_r  <= blink_sel;
            hold_cnt <= '0;
            phase    <= 1'b1;
            owner    <= grant_idx + 2'd1;
            busy     <= 1'b1;
            q        <= pat_sel;
            state    <= SHOW;
          end else begin
            q     <= idle_pat;
            owner <= 2'd0;
            busy  <= 1'b0;
          end
        end
        SHOW: begin
          q <= (blink_r && !phase) ? 8'h00 : pat_r;
          if (tick) begin
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
            phase <= ~phase;
          end
          // Release only after the minimum hold, and only to a drop or a higher requester
          if (hold_cnt == HOLD_MAX && (!cur_req || higher_req)) begin
            ack   <= 3'b001 << cur_idx;
            state <= DONE;
          end
        end
        DONE: begin
          q     <= idle_pat;
          owner <= 2'd0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Self-checking bench for led_bank_arbiter: a cycle model built from tick counts
// and ownership, plus directed scenarios with literal expectations.
module tb_led_bank_arbiter;

  localparam int MXPRE      = 3;
  localparam int HOLD_TICKS = 2;
  localparam int PERIOD     = 1 << MXPRE;

  logic        clock;
  logic        reset_n;
  logic [7:0]  idle_pat;
  logic [2:0]  req;
  logic [23:0] pat;
  logic [2:0]  blink;
  logic [2:0]  ack;
  logic        busy;
  logic [1:0]  owner;
  logic [7:0]  q;

  int checks = 0;
  int errors = 0;

  led_bank_arbiter #(.MXPRE(MXPRE), .HOLD_TICKS(HOLD_TICKS)) dut (
    .clock(clock), .reset_n(reset_n), .idle_pat(idle_pat), .req(req),
    .pat(pat), .blink(blink), .ack(ack), .busy(busy), .owner(owner), .q(q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [23:0] p, input logic [2:0] b);
    @(negedge clock);
    req   = r;
    pat   = p;
    blink = b;
  endtask

  task automatic waitAck(input string name, input logic [2:0] want, input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (ack == 3'b000 && n < budget);
    checkOutput(name, {29'd0, ack}, {29'd0, want});
  endtask

  // Reference model: who owns the bank, how many ticks it has been shown, and whether
  // this clock is the single release clock. Expected outputs are what follows each edge.
  int         m_count, m_owner, m_ticks, m_done_k, mk;
  bit         m_tick, m_leave;
  logic [7:0] m_pat;
  logic       m_blink;
  logic [7:0] exp_q;
  logic [1:0] exp_owner;
  logic       exp_busy;
  logic [2:0] exp_ack;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_count = 0; m_owner = 0; m_ticks = 0; m_done_k = -1;
      m_pat = 8'h00; m_blink = 1'b0;
      exp_q = 8'h00; exp_owner = 2'd0; exp_busy = 1'b0; exp_ack = 3'b000;
    end else begin
      m_tick = (m_count % PERIOD) == PERIOD - 1;
      m_count++;
      exp_ack = 3'b000;
      if (m_done_k >= 0) begin
        exp_q    = idle_pat;
        m_owner  = 0;
        m_done_k = -1;
      end else if (m_owner == 0) begin
        if (req != 3'b000) begin
          for (int i = 0; i < 3; i++) if (req[i]) mk = i;
          m_pat   = pat[8*mk +: 8];
          m_blink = blink[mk];
          m_ticks = 0;
          m_owner = mk + 1;
          exp_q   = m_pat;
        end else begin
          exp_q = idle_pat;
        end
      end else begin
        mk      = m_owner - 1;
        exp_q   = (m_blink && (m_ticks % 2 == 1)) ? 8'h00 : m_pat;
        m_leave = (m_ticks >= HOLD_TICKS) && (!req[mk] || ((req >> (mk + 1)) != 3'b000));
        if (m_leave) begin
          m_done_k = mk;
          exp_ack  = 3'b001 << mk;
        end
        if (m_tick) m_ticks++;
      end
      exp_owner = 2'(m_owner);
      exp_busy  = (m_owner != 0);
    end
  end

  always @(negedge clock) begin
    checkOutput("model_q", {24'd0, q}, {24'd0, exp_q});
    checkOutput("model_owner", {30'd0, owner}, {30'd0, exp_owner});
    checkOutput("model_busy", {31'd0, busy}, {31'd0, exp_busy});
    checkOutput("model_ack", {29'd0, ack}, {29'd0, exp_ack});
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit hold_ok, seen_ff, seen_00;
    reset_n  = 1'b0;
    idle_pat = 8'h01;
    req      = 3'b000;
    pat      = 24'h000000;
    blink    = 3'b000;

    // Reset state and first idle pattern
    repeat (2) @(negedge clock);
    checkOutput("rst_q", {24'd0, q}, 32'h00);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("idle_q", {24'd0, q}, 32'h01);
    checkOutput("idle_owner", {30'd0, owner}, 32'd0);
    checkOutput("idle_ack", {29'd0, ack}, 32'd0);

    // One-clock pulse on req[0] still gets the full minimum hold
    applyStimulus(3'b001, 24'h0000A5, 3'b000);
    applyStimulus(3'b000, 24'h0000A5, 3'b000);
    checkOutput("s2_q", {24'd0, q}, 32'hA5);
    checkOutput("s2_owner", {30'd0, owner}, 32'd1);
    waitAck("s2_ack", 3'b001, 40);
    @(negedge clock);
    checkOutput("s2_q_after", {24'd0, q}, 32'h01);

    // Long hold on req[2]
    applyStimulus(3'b100, 24'h3C0000, 3'b000);
    @(negedge clock);
    hold_ok = 1'b1;
    repeat (10 * PERIOD) begin
      @(negedge clock);
      if (q !== 8'h3C || owner !== 2'd3) hold_ok = 1'b0;
    end
    checkOutput("s3_hold", {31'd0, hold_ok}, 32'd1);
    applyStimulus(3'b000, 24'h3C0000, 3'b000);
    waitAck("s3_ack", 3'b100, 4);

    // Higher requester arrives mid-hold, then the preempted one is re-granted
    applyStimulus(3'b001, 24'hC3005A, 3'b000);
    repeat (PERIOD) @(negedge clock);
    applyStimulus(3'b101, 24'hC3005A, 3'b000);
    waitAck("s4_ack0", 3'b001, 40);
    repeat (2) @(negedge clock);
    checkOutput("s4_owner3", {30'd0, owner}, 32'd3);
    checkOutput("s4_q3", {24'd0, q}, 32'hC3);
    repeat (3 * PERIOD) @(negedge clock);
    applyStimulus(3'b001, 24'hC30077, 3'b000);
    waitAck("s4_ack2", 3'b100, 40);
    repeat (2) @(negedge clock);
    checkOutput("s4_owner1", {30'd0, owner}, 32'd1);
    checkOutput("s4_q_resampled", {24'd0, q}, 32'h77);
    applyStimulus(3'b000, 24'hC30077, 3'b000);
    waitAck("s4_ack0b", 3'b001, 40);

    // Blinking alert
    applyStimulus(3'b010, 24'h00FF00, 3'b010);
    @(negedge clock);
    checkOutput("s5_first", {24'd0, q}, 32'hFF);
    seen_ff = 1'b0;
    seen_00 = 1'b0;
    repeat (5 * PERIOD) begin
      @(negedge clock);
      if (owner == 2'd2 && q == 8'hFF) seen_ff = 1'b1;
      if (owner == 2'd2 && q == 8'h00) seen_00 = 1'b1;
    end
    checkOutput("s5_seen_ff", {31'd0, seen_ff}, 32'd1);
    checkOutput("s5_seen_00", {31'd0, seen_00}, 32'd1);
    applyStimulus(3'b000, 24'h00FF00, 3'b000);
    waitAck("s5_ack", 3'b010, 40);

    // Asynchronous reset in the middle of a display
    applyStimulus(3'b001, 24'h000011, 3'b000);
    repeat (5) @(negedge clock);
    checkOutput("s6_owner_pre", {30'd0, owner}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("s6_q_async", {24'd0, q}, 32'h00);
    checkOutput("s6_busy_async", {31'd0, busy}, 32'd0);
    checkOutput("s6_owner_async", {30'd0, owner}, 32'd0);
    req = 3'b000;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("s6_idle_q", {24'd0, q}, 32'h01);
    checkOutput("s6_idle_owner", {30'd0, owner}, 32'd0);
    repeat (2 * PERIOD) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
